// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver_if
// Purpose  : Bundles the data inputs and pin outputs of the seven-segment
//            scan driver.
// Signals  : value[15:0]  four hex digits, value[3:0] = digit 0 (rightmost)
//            dp[3:0]      decimal point per digit, 1 = lit
//            blank[3:0]   per-digit blank, 1 = dark
//            io_sel[3:0]  digit enables, active-low
//            io_seg[7:0]  segments {dp,g,f,e,d,c,b,a}, active-low
//            frame_tick   one-cycle pulse after each frame boundary
// Modports : master - data source / pin observer
//            slave  - the scan driver
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  io_sel;
  logic [7:0]  io_seg;
  logic        frame_tick;

  modport master (
    output value, dp, blank,
    input  io_sel, io_seg, frame_tick
  );

  modport slave (
    input  value, dp, blank,
    output io_sel, io_seg, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed driver for a 4-digit common-select seven-segment
//            display. Shadows the hex digits, dp and blank masks at frame
//            boundaries, decodes the selected digit and scans io_sel/io_seg.
// Ports    : clk  - system clock
//            rst  - synchronous reset, active-high
//            bus  - seg7_scan_driver_if.slave (value/dp/blank in,
//                   io_sel/io_seg/frame_tick out, all outputs registered)
// Params   : DIV_BITS     - slot length is 2^DIV_BITS clocks
//            BLANK_CYCLES - dark clocks at the start of each slot
// Options  : SEG7_LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//            (never digit 0, never a digit with its dp lit) are blanked.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int DIV_BITS     = 16,
  parameter int BLANK_CYCLES = 256
) (
  input  wire logic           clk,
  input  wire logic           rst,
  seg7_scan_driver_if.slave   bus
);

  localparam logic [DIV_BITS-1:0] BLANK_END = DIV_BITS'(BLANK_CYCLES);

  logic [DIV_BITS-1:0] cnt;
  logic [1:0]          idx;
  logic [15:0]         sh_value;
  logic [3:0]          sh_dp;
  logic [3:0]          sh_blank;

  logic                slot_end;
  logic                frame_end;
  logic [3:0]          nibble;
  logic [6:0]          pattern;
  logic [7:0]          seg_n;
  logic [3:0]          eff_blank_vec;

  assign slot_end  = &cnt;
  assign frame_end = slot_end && (idx == 2'd3);
  assign nibble    = sh_value[{idx, 2'b00} +: 4];
  assign seg_n     = ~{sh_dp[idx], pattern};

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits.
  always_comb begin
    pattern = 7'h00;
    case (nibble)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero and
  // its own dp is off; digit 0 always shows so a zero value reads "0".
  logic [3:0] lead_zero;
  assign lead_zero[0] = 1'b0;
  for (genvar n = 1; n < 4; n++) begin : g_lead_zero
    assign lead_zero[n] = (sh_value[15:n*4] == '0) && !sh_dp[n];
  end
  assign eff_blank_vec = sh_blank | lead_zero;
`else
  assign eff_blank_vec = sh_blank;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= 2'd0;
      sh_value       <= 16'h0000;
      sh_dp          <= 4'h0;
      sh_blank       <= 4'h0;
      bus.io_sel     <= 4'hF;
      bus.io_seg     <= 8'hFF;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
      // Capture at the wrap so the next frame starts at digit 0 with
      // a consistent set of digits.
      if (frame_end) begin
        sh_value <= bus.value;
        sh_dp    <= bus.dp;
        sh_blank <= bus.blank;
      end

      // Outputs follow the current counter state with one clock of latency.
      if ((cnt < BLANK_END) || eff_blank_vec[idx]) begin
        bus.io_sel <= 4'hF;
        bus.io_seg <= 8'hFF;
      end else begin
        bus.io_sel <= ~(4'b0001 << idx);
        bus.io_seg <= seg_n;
      end
      bus.frame_tick <= frame_end;
    end
  end

endmodule
`default_nettype wire
